// File: rtl/pfb_block_decimator_pkg.sv
// Shared types and default widths for the block-decimator multiplier scheduler.
package pfb_block_decimator_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int DEF_NUM_REQ    = 32'sd4;
  localparam int DEF_DIN0_WIDTH = 32'sd11;
  localparam int DEF_DIN1_WIDTH = 32'sd13;
  localparam int DEF_DOUT_WIDTH = 32'sd23;
  localparam int DEF_BURST_LEN  = 32'sd8;

  // Slot reached by stepping offs positions past base around an n-entry ring.
  function automatic int rr_slot(input int base, input int offs, input int n);
    return (base + offs) % n;
  endfunction

endpackage

// File: rtl/pfb_block_decimator_rr_arb.sv
// Combinational round-robin pick: first requester after last_grant, wrapping around.
module pfb_block_decimator_rr_arb
  import pfb_block_decimator_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  localparam int ID_W    = (NUM_REQ > 32'sd1) ? $clog2(NUM_REQ) : 32'sd1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    grant,
  output logic               any
);

  logic [ID_W-1:0] cand_s;

  // Scan farthest-first so the nearest requester after last_grant overrides earlier hits.
  always_comb begin
    grant  = '0;
    any    = 1'b0;
    cand_s = '0;
    for (int i = NUM_REQ; i >= 32'sd1; i--) begin
      cand_s = ID_W'(rr_slot(int'(last_grant), i, NUM_REQ));
      grant  = req[cand_s] ? cand_s : grant;
      any    = any | req[cand_s];
    end
  end

endmodule

// File: rtl/pfb_block_decimator_mul_sched.sv
// Shares one unsigned multiplier among NUM_REQ requesters, granting whole decimation
// blocks (up to BURST_LEN beats) round-robin through a two-stage operand/product pipeline.
module pfb_block_decimator_mul_sched
  import pfb_block_decimator_pkg::*;
#(
  parameter int  NUM_REQ    = DEF_NUM_REQ,
  parameter int  DIN0_WIDTH = DEF_DIN0_WIDTH,
  parameter int  DIN1_WIDTH = DEF_DIN1_WIDTH,
  parameter int  DOUT_WIDTH = DEF_DOUT_WIDTH,
  parameter int  BURST_LEN  = DEF_BURST_LEN,
  localparam int ID_W       = (NUM_REQ > 32'sd1) ? $clog2(NUM_REQ) : 32'sd1
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [DOUT_WIDTH-1:0]            rsp_dout,
  output logic [ID_W-1:0]                  rsp_id,
  output logic                             rsp_last
);

  localparam int CNT_W  = $clog2(BURST_LEN) + 32'sd1;
  localparam int PROD_W = DIN0_WIDTH + DIN1_WIDTH;

  state_e                 state_r, state_nxt_s;
  logic [ID_W-1:0]        grant_r, last_grant_r, arb_grant_s;
  logic                   arb_any_s;
  logic [CNT_W-1:0]       cnt_r;
  logic                   adv_s, accept_s, burst_end_s;
  logic [NUM_REQ-1:0]     req_ready_s;
  logic [DIN0_WIDTH-1:0]  sel_din0_s, s1_din0_r;
  logic [DIN1_WIDTH-1:0]  sel_din1_s, s1_din1_r;
  logic                   s1_valid_r, s1_last_r;
  logic [ID_W-1:0]        s1_id_r, rsp_id_r;
  logic                   rsp_valid_r, rsp_last_r;
  logic [DOUT_WIDTH-1:0]  rsp_dout_r;
  logic [PROD_W-1:0]      prod_s;

  pfb_block_decimator_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .grant      (arb_grant_s),
    .any        (arb_any_s)
  );

  // The whole pipeline moves as one: it only stalls while a product waits on downstream.
  assign adv_s      = !rsp_valid_r || rsp_ready;
  assign sel_din0_s = req_din0[int'(grant_r)*DIN0_WIDTH +: DIN0_WIDTH];
  assign sel_din1_s = req_din1[int'(grant_r)*DIN1_WIDTH +: DIN1_WIDTH];
  assign prod_s     = {{DIN1_WIDTH{1'b0}}, s1_din0_r} * {{DIN0_WIDTH{1'b0}}, s1_din1_r};

  // FSM state register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: one arbitration cycle in IDLE per grant.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = arb_any_s ? BURST : IDLE;
      BURST:   state_nxt_s = burst_end_s ? IDLE : BURST;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: only the granted requester is offered ready.
  always_comb begin
    req_ready_s = '0;
    accept_s    = 1'b0;
    burst_end_s = 1'b0;
    case (state_r)
      BURST: begin
        req_ready_s[grant_r] = adv_s;
        accept_s    = req_valid[grant_r] && adv_s;
        burst_end_s = accept_s &&
                      (req_last[grant_r] || (cnt_r == CNT_W'(BURST_LEN - 32'sd1)));
      end
      default: begin
        req_ready_s = '0;
      end
    endcase
  end

  // Grant, round-robin pointer and per-block beat counter.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      grant_r      <= '0;
      last_grant_r <= ID_W'(NUM_REQ - 32'sd1);
      cnt_r        <= '0;
    end else begin
      if ((state_r == IDLE) && arb_any_s) begin
        grant_r <= arb_grant_s;
      end
      if (burst_end_s) begin
        cnt_r        <= '0;
        last_grant_r <= grant_r;
      end else if (accept_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Operand stage then product stage; non-accepted cycles enter as bubbles.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_din0_r   <= '0;
      s1_din1_r   <= '0;
      s1_id_r     <= '0;
      s1_last_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_dout_r  <= '0;
      rsp_id_r    <= '0;
      rsp_last_r  <= 1'b0;
    end else if (adv_s) begin
      s1_valid_r  <= accept_s;
      s1_din0_r   <= sel_din0_s;
      s1_din1_r   <= sel_din1_s;
      s1_id_r     <= grant_r;
      s1_last_r   <= req_last[grant_r];
      rsp_valid_r <= s1_valid_r;
      rsp_dout_r  <= prod_s[DOUT_WIDTH-1:0];
      rsp_id_r    <= s1_id_r;
      rsp_last_r  <= s1_last_r;
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_dout  = rsp_dout_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_last  = rsp_last_r;

endmodule

// File: tb/tb_pfb_block_decimator_mul_sched.sv
// Self-checking bench: per-requester beat queues, a transaction scoreboard with arithmetic
// products, a round-robin block model, directed tables and a randomized traffic phase.
module tb_pfb_block_decimator_mul_sched;

  localparam int N  = 4;
  localparam int W0 = 11;
  localparam int W1 = 13;
  localparam int WD = 23;
  localparam int BL = 8;
  localparam int IW = 2;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_last = '0;
  logic [N*W0-1:0]   req_din0 = '0;
  logic [N*W1-1:0]   req_din1 = '0;
  logic [N-1:0]      req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [WD-1:0]     rsp_dout;
  logic [IW-1:0]     rsp_id;
  logic              rsp_last;

  pfb_block_decimator_mul_sched dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_din0(req_din0), .req_din1(req_din1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dout(rsp_dout), .rsp_id(rsp_id), .rsp_last(rsp_last)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct packed { logic [W0-1:0] a; logic [W1-1:0] b; logic last; } beat_t;
  typedef struct packed { int id; logic [WD-1:0] dout; logic last; } rsp_t;
  typedef struct { logic [W0-1:0] a; logic [W1-1:0] b; logic last; logic [WD-1:0] dout; } vec_t;

  beat_t   src_mem [N][64];
  int      head [N];
  int      tail [N];
  logic [N-1:0] vmask = '1;
  rsp_t    exp_q[$];
  rsp_t    got_q[$];
  int      acc_log[$];
  int      acc_cyc[$];
  int      fire_cyc[$];
  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;
  bit      in_burst;
  int      owner, last_m, bcnt;
  logic [N-1:0] s_ready;
  logic    s_rv;
  bit      prev_stall;
  logic [WD-1:0] prev_dout;
  logic [IW-1:0] prev_id;
  logic    prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [WD-1:0] ref_prod(input logic [W0-1:0] a, input logic [W1-1:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    return p[WD-1:0];
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (head[i] < tail[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_beat(input int r, input logic [W0-1:0] a, input logic [W1-1:0] b,
                          input logic last);
    src_mem[r][tail[r]] = '{a: a, b: b, last: last};
    tail[r]++;
  endtask

  // One clock: drive, sample at mid-cycle, update model and scoreboard, then cross the edge.
  task automatic step();
    logic [N-1:0] acc;
    logic [N-1:0] exp_rdy;
    bit was_burst;
    rsp_t e;
    for (int i = 0; i < N; i++) begin
      if (head[i] < tail[i] && vmask[i]) begin
        req_valid[i] = 1'b1;
        req_din0[i*W0 +: W0] = src_mem[i][head[i]].a;
        req_din1[i*W1 +: W1] = src_mem[i][head[i]].b;
        req_last[i] = src_mem[i][head[i]].last;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i] = 1'b0;
      end
    end
    #4;
    s_ready = req_ready;
    s_rv = rsp_valid;
    chk("ready_onehot", 64'($onehot0(req_ready)), 64'd1);
    if (prev_stall) begin
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_dout", 64'(rsp_dout), 64'(prev_dout));
      chk("stall_id", 64'(rsp_id), 64'(prev_id));
      chk("stall_last", 64'(rsp_last), 64'(prev_last));
    end
    was_burst = in_burst;
    acc = req_valid & req_ready;
    if (!was_burst) begin
      chk("arb_cycle_ready", 64'(req_ready), 64'd0);
      if (|req_valid) begin
        owner = rr_pick(req_valid, last_m);
        in_burst = 1'b1;
        bcnt = 0;
      end
    end else begin
      exp_rdy = '0;
      if (!rsp_valid || rsp_ready) exp_rdy[owner] = 1'b1;
      chk("ready_owner", 64'(req_ready), 64'(exp_rdy));
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        chk("accept_owner", 64'(i), was_burst ? 64'(owner) : 64'hFFFF_FFFF_FFFF_FFFF);
        exp_q.push_back('{id: i, dout: ref_prod(src_mem[i][head[i]].a, src_mem[i][head[i]].b),
                          last: src_mem[i][head[i]].last});
        acc_log.push_back(i);
        acc_cyc.push_back(cyc);
        if (was_burst && i == owner) begin
          bcnt++;
          if (src_mem[i][head[i]].last || bcnt == BL) begin
            in_burst = 1'b0;
            last_m = owner;
          end
        end
        head[i]++;
      end
    end
    if (rsp_valid && rsp_ready) begin
      fire_cyc.push_back(cyc);
      got_q.push_back('{id: int'(rsp_id), dout: rsp_dout, last: rsp_last});
      chk("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rsp_dout", 64'(rsp_dout), 64'(e.dout));
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_last", 64'(rsp_last), 64'(e.last));
      end
    end
    prev_stall = rsp_valid && !rsp_ready;
    prev_dout = rsp_dout;
    prev_id = rsp_id;
    prev_last = rsp_last;
    @(posedge ap_clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    vmask = '1;
    rsp_ready = 1'b1;
    while ((pending() || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_within_budget", 64'(n < budget), 64'd1);
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_last = '0;
    rsp_ready = 1'b1;
    vmask = '1;
    ap_rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_dout", 64'(rsp_dout), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_last", 64'(rsp_last), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    exp_q.delete(); got_q.delete(); acc_log.delete(); acc_cyc.delete(); fire_cyc.delete();
    in_burst = 1'b0;
    last_m = N - 1;
    prev_stall = 1'b0;
    @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v37 [3];
    int   exp38 [16];
    int   gap;
    v37[0] = '{a: 11'd2047, b: 13'd8191, last: 1'b0, dout: 23'h7FD801};
    v37[1] = '{a: 11'd1,    b: 13'd1,    last: 1'b0, dout: 23'd1};
    v37[2] = '{a: 11'd0,    b: 13'd5,    last: 1'b1, dout: 23'd0};
    exp38 = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3};

    // Single requester, three beats, fixed operands and truncated products.
    do_reset();
    for (int k = 0; k < 3; k++) add_beat(1, v37[k].a, v37[k].b, v37[k].last);
    drain(50);
    chk("t37_count", 64'(got_q.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < got_q.size()) begin
        chk("t37_dout", 64'(got_q[k].dout), 64'(v37[k].dout));
        chk("t37_id", 64'(got_q[k].id), 64'd1);
        chk("t37_last", 64'(got_q[k].last), 64'(v37[k].last));
      end
    end
    if (fire_cyc.size() > 0 && acc_cyc.size() > 0)
      chk("t37_latency", 64'(fire_cyc[0] - acc_cyc[0]), 64'd2);

    // All four requesters, two 2-beat blocks each: strict rotation 0,1,2,3,0,...
    do_reset();
    for (int r = 0; r < N; r++)
      for (int k = 0; k < 4; k++)
        add_beat(r, W0'($urandom), W1'($urandom), (k % 2) == 1);
    drain(200);
    chk("t38_count", 64'(acc_log.size()), 64'd16);
    for (int k = 0; k < 16; k++)
      if (k < acc_log.size()) chk("t38_grant_order", 64'(acc_log[k]), 64'(exp38[k]));
    chk("t38_rsp_count", 64'(got_q.size()), 64'd16);

    // Ten beats without an end marker: block cut after BURST_LEN beats.
    do_reset();
    for (int k = 0; k < 10; k++) add_beat(2, W0'($urandom), W1'($urandom), 1'b0);
    drain(100);
    chk("t39_count", 64'(acc_cyc.size()), 64'd10);
    if (acc_cyc.size() == 10) begin
      chk("t39_first_block_span", 64'(acc_cyc[7] - acc_cyc[0]), 64'd7);
      chk("t39_regrant_gap", 64'(acc_cyc[8] - acc_cyc[7]), 64'd2);
    end
    chk("t39_rsp_count", 64'(got_q.size()), 64'd10);

    // Downstream stall mid-burst.
    do_reset();
    for (int k = 0; k < 6; k++) add_beat(3, W0'($urandom), W1'($urandom), k == 5);
    for (int k = 0; k < 4; k++) step();
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t40_ready_low", 64'(s_ready), 64'd0);
      chk("t40_valid_held", 64'(s_rv), 64'd1);
    end
    drain(100);
    chk("t40_rsp_count", 64'(got_q.size()), 64'd6);

    // Reset with beats in flight; first grant after release goes to requester 0.
    do_reset();
    for (int k = 0; k < 4; k++) add_beat(1, W0'($urandom), W1'($urandom), k == 3);
    for (int k = 0; k < 3; k++) step();
    chk("t41_inflight_valid", 64'(rsp_valid), 64'd1);
    do_reset();
    for (int k = 0; k < 2; k++) add_beat(3, W0'($urandom), W1'($urandom), k == 1);
    for (int k = 0; k < 2; k++) add_beat(0, W0'($urandom), W1'($urandom), k == 1);
    drain(100);
    if (acc_log.size() > 0) chk("t41_first_grant", 64'(acc_log[0]), 64'd0);
    chk("t41_rsp_count", 64'(got_q.size()), 64'd4);

    // Granted requester pauses: grant kept, bubble on the response side.
    do_reset();
    for (int k = 0; k < 5; k++) add_beat(0, W0'($urandom), W1'($urandom), k == 4);
    for (int k = 0; k < 2; k++) add_beat(1, W0'($urandom), W1'($urandom), k == 1);
    for (int k = 0; k < 3; k++) step();
    vmask[0] = 1'b0;
    for (int k = 0; k < 3; k++) step();
    drain(100);
    for (int k = 0; k < 5; k++)
      if (k < acc_log.size()) chk("t42_grant_held", 64'(acc_log[k]), 64'd0);
    gap = 0;
    for (int k = 1; k < 5; k++)
      if (k < fire_cyc.size() && fire_cyc[k] - fire_cyc[k-1] > gap) gap = fire_cyc[k] - fire_cyc[k-1];
    chk("t42_bubble_seen", 64'(gap > 1), 64'd1);
    chk("t42_rsp_count", 64'(got_q.size()), 64'd7);

    // Randomized traffic: random valids, pauses, block ends and backpressure.
    do_reset();
    for (int r = 0; r < N; r++)
      for (int k = 0; k < 12; k++)
        add_beat(r, W0'($urandom), W1'($urandom), (k == 11) || ($urandom_range(0, 3) == 0));
    for (int k = 0; k < 250; k++) begin
      vmask = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(3000);
    chk("rand_rsp_count", 64'(got_q.size()), 64'd48);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
